// File: rtl/node_dir_sequencer.sv
// Path direction sequencer for the line follower: stores a path of turn codes loaded
// over a valid/ready port and replays one entry per completed node (node_clk falling edge).
module node_dir_sequencer #(
  parameter int           DEPTH     = 16,
  parameter int           IDX_W     = 5,
  parameter logic [2:0]   STOP_CODE = 3'd7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       dir_in,
  input  logic             dir_valid,
  output logic             dir_ready,
  input  logic             start,
  input  logic             clear,
  input  logic             node_clk,
  input  logic             fault,
  output logic [2:0]       direction,
  output logic [IDX_W-1:0] node_idx,
  output logic             busy,
  output logic             done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_W = IDX_W'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] rd_ptr;
  logic             node_prev;
  logic [2:0]       path_mem [DEPTH];

  logic             wr_accept;
  logic             node_done;
  logic [IDX_W-1:0] nxt_ptr;
  logic [2:0]       first_dir;

  assign dir_ready = (state == ST_IDLE) && (count < DEPTH_W);
  assign wr_accept = dir_ready && dir_valid && !clear;
  assign node_done = node_prev && !node_clk;
  assign nxt_ptr   = rd_ptr + 1'b1;
  // A write on the same edge as start with an empty path becomes entry 0 directly.
  assign first_dir = (count == '0) ? dir_in : path_mem[0];

  assign busy = (state == ST_RUN) || (state == ST_HALT);
  assign done = (state == ST_DONE);

  // NOTE: path storage has no reset; its contents are only read below count, which is reset.
  always_ff @(posedge clk) begin
    if (wr_accept) path_mem[count[AW-1:0]] <= dir_in;
  end

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      node_idx  <= '0;
      direction <= STOP_CODE;
      node_prev <= 1'b0;
    end else begin
      // History is tracked in every state so a resume never sees a stale edge.
      node_prev <= node_clk;
      if (clear) begin
        state     <= ST_IDLE;
        count     <= '0;
        rd_ptr    <= '0;
        node_idx  <= '0;
        direction <= STOP_CODE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (wr_accept) count <= count + 1'b1;
            if (start && ((count != '0) || wr_accept)) begin
              state     <= ST_RUN;
              rd_ptr    <= '0;
              node_idx  <= '0;
              direction <= first_dir;
            end
          end
          ST_RUN: begin
            if (fault) begin
              state     <= ST_HALT;
              direction <= STOP_CODE;
            end else if (node_done) begin
              node_idx <= node_idx + 1'b1;
              rd_ptr   <= nxt_ptr;
              if (nxt_ptr == count) begin
                state     <= ST_DONE;
                direction <= STOP_CODE;
              end else begin
                direction <= path_mem[nxt_ptr[AW-1:0]];
              end
            end
          end
          ST_HALT: begin
            if (!fault) begin
              state     <= ST_RUN;
              direction <= path_mem[rd_ptr[AW-1:0]];
            end
          end
          default: begin
            direction <= STOP_CODE;
            if (start) begin
              state     <= ST_RUN;
              rd_ptr    <= '0;
              node_idx  <= '0;
              direction <= path_mem[0];
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_node_dir_sequencer.sv
// Directed self-checking bench for node_dir_sequencer: load, replay, overflow,
// fault freeze, clear/reset and replay-from-DONE scenarios with hand-computed values.
module tb_node_dir_sequencer;

  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       dir_in;
  logic             dir_valid;
  logic             dir_ready;
  logic             start;
  logic             clear;
  logic             node_clk;
  logic             fault;
  logic [2:0]       direction;
  logic [IDX_W-1:0] node_idx;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  node_dir_sequencer #(.DEPTH(16), .IDX_W(IDX_W), .STOP_CODE(3'd7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir_in    (dir_in),
    .dir_valid (dir_valid),
    .dir_ready (dir_ready),
    .start     (start),
    .clear     (clear),
    .node_clk  (node_clk),
    .fault     (fault),
    .direction (direction),
    .node_idx  (node_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] d);
    dir_in = d; dir_valid = 1'b1;
    step(1);
    dir_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic node_pass(input int high_cycles);
    node_clk = 1'b1; step(high_cycles);
    node_clk = 1'b0; step(1);
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; dir_in = '0; dir_valid = 1'b0; start = 1'b0;
    clear = 1'b0; node_clk = 1'b0; fault = 1'b0;
    step(2);
    check("rst_dir", direction, 7);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", node_idx, 0);
    check("rst_ready", dir_ready, 1);
    rst_n = 1'b1;
    step(1);

    // 1: basic replay of {1,2,0}
    push(3'd1); push(3'd2); push(3'd0);
    pulse_start();
    check("t1_dir0", direction, 1);
    check("t1_busy", busy, 1);
    check("t1_ready_run", dir_ready, 0);
    node_clk = 1'b1; step(5);
    check("t1_rise_dir", direction, 1);
    check("t1_rise_idx", node_idx, 0);
    node_clk = 1'b0; step(1);
    check("t1_dir1", direction, 2);
    check("t1_idx1", node_idx, 1);
    node_pass(3);
    check("t1_dir2", direction, 0);
    check("t1_idx2", node_idx, 2);
    node_pass(3);
    check("t1_done", done, 1);
    check("t1_done_dir", direction, 7);
    check("t1_done_idx", node_idx, 3);
    check("t1_done_busy", busy, 0);
    check("t1_done_ready", dir_ready, 0);

    // 6: replay from DONE; a rising edge alone changes nothing
    pulse_start();
    check("t6_dir", direction, 1);
    check("t6_idx", node_idx, 0);
    check("t6_busy", busy, 1);
    check("t6_done", done, 0);
    node_clk = 1'b1; step(3);
    check("t6_rise_dir", direction, 1);
    check("t6_rise_idx", node_idx, 0);
    node_clk = 1'b0; step(1);
    check("t6_fall_dir", direction, 2);
    check("t6_fall_idx", node_idx, 1);

    // 5a: clear mid-RUN
    pulse_clear();
    check("t5_clr_busy", busy, 0);
    check("t5_clr_dir", direction, 7);
    check("t5_clr_idx", node_idx, 0);
    check("t5_clr_ready", dir_ready, 1);

    // 4: start on the now-empty path is ignored
    pulse_start();
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_dir", direction, 7);

    // start together with the first write runs a one-entry path
    dir_in = 3'd3; dir_valid = 1'b1; start = 1'b1;
    step(1);
    dir_valid = 1'b0; start = 1'b0;
    check("sw_busy", busy, 1);
    check("sw_dir", direction, 3);
    node_pass(2);
    check("sw_done", done, 1);
    check("sw_idx", node_idx, 1);
    check("sw_dir_end", direction, 7);

    // 3: fault freeze on path {2,1}
    pulse_clear();
    push(3'd2); push(3'd1);
    pulse_start();
    check("t3_dir0", direction, 2);
    node_pass(2);
    check("t3_dir1", direction, 1);
    check("t3_idx1", node_idx, 1);
    fault = 1'b1; step(1);
    check("t3_halt_dir", direction, 7);
    check("t3_halt_busy", busy, 1);
    node_clk = 1'b1; step(3);
    node_clk = 1'b0; step(2);
    check("t3_halt_idx", node_idx, 1);
    check("t3_halt_dir2", direction, 7);
    fault = 1'b0; step(1);
    check("t3_resume_dir", direction, 1);
    check("t3_resume_idx", node_idx, 1);
    // fault on the same edge as a completion wins
    node_clk = 1'b1; step(3);
    node_clk = 1'b0; fault = 1'b1; step(1);
    check("t3_tie_dir", direction, 7);
    check("t3_tie_idx", node_idx, 1);
    fault = 1'b0; step(2);
    check("t3_tie_resume_dir", direction, 1);
    check("t3_tie_resume_idx", node_idx, 1);
    node_pass(2);
    check("t3_end_done", done, 1);
    check("t3_end_idx", node_idx, 2);

    // 5b: synchronous reset mid-RUN loses the path
    pulse_clear();
    push(3'd1); push(3'd2);
    pulse_start();
    check("t5_run_busy", busy, 1);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_dir", direction, 7);
    check("t5_rst_idx", node_idx, 0);
    pulse_start();
    check("t5_rst_empty", busy, 0);

    // 2: offer 17 entries with dir_valid held; data advances only on accept
    acc = 0;
    dir_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dir_in = 3'(acc);
      if (dir_ready) acc++;
      step(1);
      if (acc == 17) break;
    end
    dir_valid = 1'b0;
    check("t2_accepted", acc, 16);
    check("t2_ready_full", dir_ready, 0);
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      check("t2_replay_dir", direction, k % 8);
      check("t2_replay_idx", node_idx, k);
      node_pass(1);
    end
    check("t2_done", done, 1);
    check("t2_idx_max", node_idx, 16);
    check("t2_end_dir", direction, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
